// File: rtl/seq_divider16.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready in and out.
// Define SEQ_DIVIDER16_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] rsr;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rshift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rnext;
  logic [WIDTH-1:0] qnext;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef SEQ_DIVIDER16_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fin = neg_q ? -qnext : qnext;
    r_fin = neg_r ? -rnext : rnext;
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fin = qnext;
    r_fin = rnext;
  end
`endif

  // The stored partial remainder is always < divisor, so its extra top bit is
  // kept only in the shifted/subtracted intermediate, not in the register.
  always_comb begin
    rshift = {rsr, qsr[WIDTH-1]};
    diff   = rshift - {1'b0, dsr};
    if (!diff[WIDTH]) begin
      rnext = diff[WIDTH-1:0];
      qnext = {qsr[WIDTH-2:0], 1'b1};
    end else begin
      rnext = rshift[WIDTH-1:0];
      qnext = {qsr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      qsr         <= '0;
      rsr         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              qsr   <= a_mag;
              rsr   <= '0;
              dsr   <= b_mag;
              cnt   <= '0;
              state <= CALC;
`ifdef SEQ_DIVIDER16_SIGNED_EN
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          qsr <= qnext;
          rsr <= rnext;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed and random checks of seq_divider16 (signed cases under SEQ_DIVIDER16_SIGNED_EN).
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers only; every comparison is made in the test tasks.
  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit ok);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (quotient !== 16'h0) begin n_err++; $display("FAIL rst_quotient: got %h want 0000", quotient); end
    n_cmp++; if (remainder !== 16'h0) begin n_err++; $display("FAIL rst_remainder: got %h want 0000", remainder); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL rst_dbz: got %b want 0", div_by_zero); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    bit ok; int cyc;
    out_ready = 1'b1;
    send(16'd1000, 16'd7, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", ok); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_calc: got %b want 0", in_ready); end
    wait_out(cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: got %b want 1", ok); end
    n_cmp++; if (cyc != 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", cyc); end
    n_cmp++; if (quotient !== 16'd142) begin n_err++; $display("FAIL basic_quotient: got %0d want 142", quotient); end
    n_cmp++; if (remainder !== 16'd6) begin n_err++; $display("FAIL basic_remainder: got %0d want 6", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_handoff_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after: got %b want 1", in_ready); end
    n_cmp++; if (quotient !== 16'd142) begin n_err++; $display("FAIL basic_hold_quotient: got %0d want 142", quotient); end
  endtask

  task automatic test_extremes;
    logic [15:0] va [2] = '{16'hFFFF, 16'h0005};
    logic [15:0] vb [2] = '{16'h0001, 16'h0009};
    logic [15:0] eq [2] = '{16'hFFFF, 16'h0000};
    logic [15:0] er [2] = '{16'h0000, 16'h0005};
    bit ok; int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(va[i], vb[i], ok);
      wait_out(cyc, ok);
      n_cmp++; if (ok !== 1'b1 || cyc != 17) begin n_err++; $display("FAIL ext%0d_latency: got %0d want 17", i, cyc); end
      n_cmp++; if (quotient !== eq[i]) begin n_err++; $display("FAIL ext%0d_quotient: got %h want %h", i, quotient, eq[i]); end
      n_cmp++; if (remainder !== er[i]) begin n_err++; $display("FAIL ext%0d_remainder: got %h want %h", i, remainder, er[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    bit ok; int cyc;
    out_ready = 1'b1;
    send(16'h1234, 16'h0000, ok);
    wait_out(cyc, ok);
    n_cmp++; if (ok !== 1'b1 || cyc != 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", cyc); end
    n_cmp++; if (quotient !== 16'hFFFF) begin n_err++; $display("FAIL dz_quotient: got %h want ffff", quotient); end
    n_cmp++; if (remainder !== 16'h1234) begin n_err++; $display("FAIL dz_remainder: got %h want 1234", remainder); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    @(posedge clk); #1;
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_flag_clear: got %b want 0", div_by_zero); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dz_valid_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    bit ok; int cyc;
    out_ready = 1'b0;
    send(16'd100, 16'd10, ok);
    wait_out(cyc, ok);
    n_cmp++; if (ok !== 1'b1 || cyc != 17) begin n_err++; $display("FAIL bp_latency: got %0d want 17", cyc); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (quotient !== 16'd10 || remainder !== 16'd0) begin n_err++; $display("FAIL bp_hold_%0d: got %0d/%0d want 10/0", i, quotient, remainder); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
      if (i == 2) begin dividend = 16'd7; divisor = 16'd7; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got ready=%b busy=%b want 1/0", in_ready, busy); end
    n_cmp++; if (quotient !== 16'd10) begin n_err++; $display("FAIL bp_keep_quotient: got %0d want 10", quotient); end
  endtask

  task automatic test_reset_midop;
    bit ok; int cyc;
    out_ready = 1'b1;
    send(16'd50000, 16'd3, ok);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got valid=%b busy=%b want 0/0", out_valid, busy); end
    n_cmp++; if (quotient !== 16'h0 || remainder !== 16'h0) begin n_err++; $display("FAIL mid_rst_outputs: got %h/%h want 0000/0000", quotient, remainder); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    send(16'd50000, 16'd3, ok);
    wait_out(cyc, ok);
    n_cmp++; if (ok !== 1'b1 || cyc != 17) begin n_err++; $display("FAIL mid_rerun_latency: got %0d want 17", cyc); end
    n_cmp++; if (quotient !== 16'd16666 || remainder !== 16'd2) begin n_err++; $display("FAIL mid_rerun_result: got %0d/%0d want 16666/2", quotient, remainder); end
    @(posedge clk); #1;
  endtask

`ifdef SEQ_DIVIDER16_SIGNED_EN
  task automatic test_signed;
    bit ok; int cyc;
    out_ready = 1'b1;
    send(16'hFFF9, 16'h0002, ok);
    wait_out(cyc, ok);
    n_cmp++; if (ok !== 1'b1 || cyc != 17) begin n_err++; $display("FAIL s_latency: got %0d want 17", cyc); end
    n_cmp++; if (quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin n_err++; $display("FAIL s_m7_2: got %h/%h want fffd/ffff", quotient, remainder); end
    @(posedge clk); #1;
    send(16'h8000, 16'hFFFF, ok);
    wait_out(cyc, ok);
    n_cmp++; if (quotient !== 16'h8000 || remainder !== 16'h0000) begin n_err++; $display("FAIL s_minneg: got %h/%h want 8000/0000", quotient, remainder); end
    @(posedge clk); #1;
    send(16'h8000, 16'h0000, ok);
    wait_out(cyc, ok);
    n_cmp++; if (quotient !== 16'hFFFF || remainder !== 16'h8000 || div_by_zero !== 1'b1) begin n_err++; $display("FAIL s_dz: got %h/%h/%b want ffff/8000/1", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_random;
    bit ok; int cyc;
    logic [15:0] a, b, eq, er;
    int ai, bi;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = (i % 2 == 0) ? 16'($urandom_range(255, 1)) : 16'($urandom_range(65535, 1));
`ifdef SEQ_DIVIDER16_SIGNED_EN
      ai = int'($signed(a));
      bi = int'($signed(b));
`else
      ai = int'({16'h0, a});
      bi = int'({16'h0, b});
`endif
      eq = 16'(ai / bi);
      er = 16'(ai % bi);
      send(a, b, ok);
      wait_out(cyc, ok);
      n_cmp++; if (ok !== 1'b1 || quotient !== eq) begin n_err++; $display("FAIL rnd%0d_quotient: %h/%h got %h want %h", i, a, b, quotient, eq); end
      n_cmp++; if (remainder !== er) begin n_err++; $display("FAIL rnd%0d_remainder: %h/%h got %h want %h", i, a, b, remainder, er); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_midop();
`ifdef SEQ_DIVIDER16_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
